// File: rtl/lzc_pkg.sv
// Shared types and defaults for the lzc scheduler and the lzc unit it feeds.
package lzc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } lzc_sched_state_t;

    localparam int LZC_WIDTH = 8;
    localparam int LZC_WORD  = 4;

    // Width of a leading-zero count that must also represent the all-zero case.
    function automatic int lzc_zw(input int width, input int word);
        return $clog2(width * word) + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   id
);

    logic [IW:0] idx;
    logic        found;

    // One extra bit on idx keeps ptr+i from overflowing before the wrap.
    always_comb begin
        gnt   = '0;
        id    = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = {1'b0, ptr} + (IW+1)'(i);
            if (idx >= (IW+1)'(NREQ)) begin
                idx = idx - (IW+1)'(NREQ);
            end
            if (!found && req[idx[IW-1:0]]) begin
                found = 1'b1;
                id    = idx[IW-1:0];
            end
        end
        if (en && found) begin
            gnt[id] = 1'b1;
        end
    end

endmodule

// File: rtl/lzc_sched.sv
// Round-robin scheduler sharing one lzc unit: grant, stream WORD beats MSB first,
// wait for the count (or time out), then return it tagged with the requester id.
module lzc_sched
    import lzc_pkg::*;
#(
    parameter  int WIDTH   = LZC_WIDTH,
    parameter  int WORD    = LZC_WORD,
    parameter  int NREQ    = 4,
    parameter  int TIMEOUT = 16,
    localparam int ZW      = lzc_zw(WIDTH, WORD),
    localparam int IW      = $clog2(NREQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NREQ-1:0]              req,
    input  logic [NREQ*WIDTH*WORD-1:0]   req_data,
    input  logic [NREQ-1:0]              req_mode,
    output logic [NREQ-1:0]              gnt,
    output logic                         rsp_valid,
    output logic [IW-1:0]                rsp_id,
    output logic [ZW-1:0]                rsp_zeros,
    output logic                         rsp_err,
    output logic                         busy,
    output logic [WIDTH-1:0]             lzc_data,
    output logic                         lzc_ivalid,
    output logic                         lzc_mode,
    input  logic [ZW-1:0]                lzc_zeros,
    input  logic                         lzc_ovalid
);

    localparam int OPW = WIDTH * WORD;
    localparam int BW  = $clog2(WORD + 1);
    localparam int TW  = $clog2(TIMEOUT + 1);

    localparam logic [BW-1:0] LAST_BEAT = BW'(WORD - 1);
    localparam logic [TW-1:0] LAST_TMO  = TW'(TIMEOUT - 1);
    localparam logic [IW-1:0] LAST_ID   = IW'(NREQ - 1);

    lzc_sched_state_t state_q, state_d;

    logic [IW-1:0]    rr_ptr_q;
    logic [IW-1:0]    id_q;
    logic [OPW-1:0]   op_q;
    logic [BW-1:0]    beat_q;
    logic [TW-1:0]    tmo_q;

    logic [WIDTH-1:0] lzc_data_q;
    logic             lzc_ivalid_q;
    logic             lzc_mode_q;
    logic             rsp_valid_q;
    logic [IW-1:0]    rsp_id_q;
    logic [ZW-1:0]    rsp_zeros_q;
    logic             rsp_err_q;
    logic             busy_q;

    logic [NREQ-1:0]  arb_gnt;
    logic [IW-1:0]    arb_id;
    logic             arb_en;
    logic             granted;
    logic [OPW-1:0]   sel_op;
    logic             sel_mode;
    logic [IW-1:0]    next_ptr;

    assign arb_en  = (state_q == IDLE);
    assign granted = |arb_gnt;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req (req),
        .ptr (rr_ptr_q),
        .en  (arb_en),
        .gnt (arb_gnt),
        .id  (arb_id)
    );

    always_comb begin
        sel_op   = '0;
        sel_mode = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) begin
                sel_op   = req_data[i*OPW +: OPW];
                sel_mode = req_mode[i];
            end
        end
    end

    assign next_ptr = (arb_id == LAST_ID) ? '0 : arb_id + IW'(1);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (granted) state_d = ISSUE;
            ISSUE:   if (beat_q == LAST_BEAT) state_d = WAIT;
            WAIT:    if (lzc_ovalid || tmo_q == LAST_TMO) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The operand is kept pre-shifted so the next beat is always its top WIDTH bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            id_q         <= '0;
            op_q         <= '0;
            beat_q       <= '0;
            tmo_q        <= '0;
            lzc_data_q   <= '0;
            lzc_ivalid_q <= 1'b0;
            lzc_mode_q   <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_zeros_q  <= '0;
            rsp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= (state_d != IDLE);
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (granted) begin
                        op_q         <= sel_op << WIDTH;
                        lzc_data_q   <= sel_op[OPW-1 -: WIDTH];
                        lzc_ivalid_q <= 1'b1;
                        lzc_mode_q   <= sel_mode;
                        id_q         <= arb_id;
                        beat_q       <= '0;
                        rr_ptr_q     <= next_ptr;
                    end
                end
                ISSUE: begin
                    if (beat_q == LAST_BEAT) begin
                        lzc_ivalid_q <= 1'b0;
                        tmo_q        <= '0;
                    end else begin
                        beat_q     <= beat_q + BW'(1);
                        lzc_data_q <= op_q[OPW-1 -: WIDTH];
                        op_q       <= op_q << WIDTH;
                    end
                end
                WAIT: begin
                    if (lzc_ovalid) begin
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= id_q;
                        rsp_zeros_q <= lzc_zeros;
                        rsp_err_q   <= 1'b0;
                    end else if (tmo_q == LAST_TMO) begin
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= id_q;
                        rsp_zeros_q <= '0;
                        rsp_err_q   <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                RESP: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign gnt        = arb_gnt;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_zeros  = rsp_zeros_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = busy_q;
    assign lzc_data   = lzc_data_q;
    assign lzc_ivalid = lzc_ivalid_q;
    assign lzc_mode   = lzc_mode_q;

endmodule
